mac_vector_seq: RTL

- Sequencer that time-multiplexes one MultAdd instance (y = a*b + c, signed, BIT_WIDTH) to compute a dot product plus bias: result = bias + sum(a[i]*b[i]), i = 0..len-1.
- Sits between the hash-projection operand streams and the downstream hash/sign stage.
- Accepts one operand pair per cycle over a valid/ready handshake.
- Holds the scalar result until the consumer accepts it.

---
 rtl/mac_vector_seq_if.sv | 28 ++
 rtl/mac_vector_seq.sv | 96 +++++++++
 2 files changed

// File: rtl/mac_vector_seq_if.sv
// Operand, result and job-control signals of the dot-product sequencer.
// The sequencer sits on the slave modport; the operand source and consumer sit on master.
interface mac_vector_seq_if #(
  parameter int BIT_WIDTH = 16,
  parameter int LEN_WIDTH = 8
);
  logic                        start;
  logic [LEN_WIDTH-1:0]        len;
  logic signed [BIT_WIDTH-1:0] bias;
  logic                        in_valid;
  logic                        in_ready;
  logic signed [BIT_WIDTH-1:0] in_a;
  logic signed [BIT_WIDTH-1:0] in_b;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [BIT_WIDTH-1:0] out_data;
  logic                        busy;

  modport master (
    output start, len, bias, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  start, len, bias, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/mac_vector_seq.sv
// Dot product plus bias through one shared multiply-add, one operand pair per cycle.
// Build option MAC_VECTOR_SEQ_RELU_EN clamps negative results to zero at the output.
//
// state | meaning
// IDLE  | waiting for start; out_data holds the previous result
// ACC   | accepting operand pairs, cnt counts pairs still owed
// DONE  | result presented, waiting for out_ready
module mac_vector_seq #(
  parameter int BIT_WIDTH = 16,
  parameter int LEN_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  mac_vector_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                      state, state_nxt;
  logic signed [BIT_WIDTH-1:0] acc, acc_nxt;
  logic signed [BIT_WIDTH-1:0] mac;
  logic signed [BIT_WIDTH-1:0] res;
  logic signed [BIT_WIDTH-1:0] out_data_q;
  logic [LEN_WIDTH-1:0]        cnt, cnt_nxt;
  logic                        load_out;
  logic                        in_ready_int;

  // Only the low BIT_WIDTH bits of the full product survive the final wrap,
  // so forming the sum at BIT_WIDTH gives exactly the truncated a*b + c.
  assign mac = bus.in_a * bus.in_b + acc;

`ifdef MAC_VECTOR_SEQ_RELU_EN
  assign res = acc_nxt[BIT_WIDTH-1] ? '0 : acc_nxt;
`else
  assign res = acc_nxt;
`endif

  assign in_ready_int  = (state == ACC);
  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_data  = out_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    load_out  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          acc_nxt = bus.bias;
          cnt_nxt = bus.len;
          if (bus.len == '0) begin
            state_nxt = DONE;
            load_out  = 1'b1;
          end else begin
            state_nxt = ACC;
          end
        end
      end
      ACC: begin
        if (bus.in_valid && in_ready_int) begin
          acc_nxt = mac;
          cnt_nxt = cnt - LEN_WIDTH'(1);
          if (cnt == LEN_WIDTH'(1)) begin
            state_nxt = DONE;
            load_out  = 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc        <= '0;
      cnt        <= '0;
      out_data_q <= '0;
    end else begin
      acc <= acc_nxt;
      cnt <= cnt_nxt;
      if (load_out) out_data_q <= res;
    end
  end

endmodule
